// File: rtl/mips_core_if.sv
// Instruction/data memory bus between the single-cycle MIPS core and its imem/dmem.
interface mips_core_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output pc, memwrite, aluout, writedata,
    input  instr, readdata
  );

  modport slave (
    input  pc, memwrite, aluout, writedata,
    output instr, readdata
  );
endinterface

// File: rtl/mips_core.sv
// Single-cycle MIPS32 core: decoder, 32x32 register file, ALU and next-pc logic.
// Memories are external; instr and readdata are consumed in the same cycle.
module mips_core (
  input  logic   clk,
  input  logic   reset,
  mips_core_if.master bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned NREG = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [DW-1:0] pc_q;
  logic [DW-1:0] rf [NREG];

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [RW-1:0] rs;
  logic [RW-1:0] rt;
  logic [RW-1:0] rd;
  logic [DW-1:0] simm;

  assign op    = bus.instr[31:26];
  assign rs    = bus.instr[25:21];
  assign rt    = bus.instr[20:16];
  assign rd    = bus.instr[15:11];
  assign funct = bus.instr[5:0];
  assign simm  = {{16{bus.instr[15]}}, bus.instr[15:0]};

  logic          regwrite;
  logic          regdst;
  logic          alusrc;
  logic          memtoreg;
  logic          memwrite_c;
  logic          branch;
  logic          jump;
  logic [2:0]    alucontrol;

  // Instruction decode; anything unrecognised falls through as a no-op.
  always_comb begin
    regwrite   = 1'b0;
    regdst     = 1'b0;
    alusrc     = 1'b0;
    memtoreg   = 1'b0;
    memwrite_c = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alucontrol = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        regdst = 1'b1;
        case (funct)
          FN_ADD: begin regwrite = 1'b1; alucontrol = ALU_ADD; end
          FN_SUB: begin regwrite = 1'b1; alucontrol = ALU_SUB; end
          FN_AND: begin regwrite = 1'b1; alucontrol = ALU_AND; end
          FN_OR:  begin regwrite = 1'b1; alucontrol = ALU_OR;  end
          FN_SLT: begin regwrite = 1'b1; alucontrol = ALU_SLT; end
          default: ;
        endcase
      end
      OP_LW: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        memtoreg = 1'b1;
      end
      OP_SW: begin
        alusrc     = 1'b1;
        memwrite_c = 1'b1;
      end
      OP_BEQ: begin
        branch     = 1'b1;
        alucontrol = ALU_SUB;
      end
      OP_ADDI: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
      end
      OP_J: jump = 1'b1;
      default: ;
    endcase
  end

  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [DW-1:0] srcb;
  logic [DW-1:0] alu_res;
  logic          zero;

  assign rd1  = (rs == '0) ? '0 : rf[rs];
  assign rd2  = (rt == '0) ? '0 : rf[rt];
  assign srcb = alusrc ? simm : rd2;

  always_comb begin
    alu_res = '0;
    case (alucontrol)
      ALU_AND: alu_res = rd1 & srcb;
      ALU_OR:  alu_res = rd1 | srcb;
      ALU_ADD: alu_res = rd1 + srcb;
      ALU_SUB: alu_res = rd1 - srcb;
      ALU_SLT: alu_res = DW'($signed(rd1) < $signed(srcb));
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  logic [DW-1:0] pcplus4;
  logic [DW-1:0] pcnext;
  logic [RW-1:0] waddr;
  logic [DW-1:0] wdata;

  assign pcplus4 = pc_q + DW'(4);
  assign waddr   = regdst ? rd : rt;
  assign wdata   = memtoreg ? bus.readdata : alu_res;

  always_comb begin
    pcnext = pcplus4;
    if (jump)
      pcnext = {pcplus4[31:28], bus.instr[25:0], 2'b00};
    else if (branch && zero)
      pcnext = pcplus4 + {simm[29:0], 2'b00};
  end

  // pc and register file commit; $0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else begin
      pc_q <= pcnext;
      if (regwrite && (waddr != '0)) rf[waddr] <= wdata;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.memwrite  = memwrite_c;
  assign bus.aluout    = alu_res;
  assign bus.writedata = rd2;

endmodule

// File: tb/tb_mips_core.sv
// Self-checking bench for mips_core: per-instruction expectations queued at issue,
// compared against the combinational outputs and the committed pc.
module tb_mips_core;

  logic clk;
  logic reset;
  mips_core_if bus ();

  mips_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic        chk_alu;
    logic [31:0] alu;
    logic        mw;
    logic [31:0] wd;
    logic [31:0] npc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int s, input int t, input int d, input logic [5:0] f);
    return {6'b000000, 5'(s), 5'(t), 5'(d), 5'b00000, f};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t,
                                        input logic [15:0] imm);
    return {op, 5'(s), 5'(t), imm};
  endfunction

  // Entered at a falling edge; drives one instruction and checks it through commit.
  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] rdata,
                       input logic chk_alu, input logic [31:0] alu, input logic mw,
                       input logic [31:0] wd, input logic [31:0] npc);
    exp_t e;
    bus.instr    = ins;
    bus.readdata = rdata;
    sbq.push_back('{tag, chk_alu, alu, mw, wd, npc});
    #2;
    e = sbq.pop_front();
    if (e.chk_alu) chk({e.tag, ".alu"}, bus.aluout, e.alu);
    chk({e.tag, ".mw"}, 32'(bus.memwrite), 32'(e.mw));
    chk({e.tag, ".wd"}, bus.writedata, e.wd);
    @(posedge clk);
    #1;
    chk({e.tag, ".pc"}, bus.pc, e.npc);
    @(negedge clk);
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    bus.instr    = '0;
    bus.readdata = '0;
    #1 chk("reset.pc", bus.pc, 32'h0);
    @(posedge clk); #1 chk("reset_hold.pc", bus.pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    issue("nop0", 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);
    issue("nop1", 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h8);
    issue("addi1", i_ins(ADDI, 0, 1, 16'd3), 32'h0, 1'b1, 32'h3, 1'b0, 32'h0, 32'hC);

    // Asynchronous reset mid-run clears pc and $1
    #1 reset = 1'b1;
    bus.instr = '0;
    #1 chk("midrst.pc", bus.pc, 32'h0);
    @(posedge clk); #1 chk("midrst_hold.pc", bus.pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    issue("lw", i_ins(LW, 1, 2, 16'd4), 32'hDEADBEEF, 1'b1, 32'h4, 1'b0, 32'h0, 32'h4);
    issue("sw2", i_ins(SW, 1, 2, 16'd4), 32'h0, 1'b1, 32'h4, 1'b1, 32'hDEADBEEF, 32'h8);
    issue("addi3", i_ins(ADDI, 0, 3, 16'd5), 32'h0, 1'b1, 32'h5, 1'b0, 32'h0, 32'hC);
    issue("addi4", i_ins(ADDI, 0, 4, 16'd7), 32'h0, 1'b1, 32'h7, 1'b0, 32'h0, 32'h10);
    issue("beq_nt", i_ins(BEQ, 3, 4, 16'd2), 32'h0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h7, 32'h14);
    issue("j_back", {J, 26'h4}, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h10);
    issue("beq_t", i_ins(BEQ, 3, 3, 16'd2), 32'h0, 1'b1, 32'h0, 1'b0, 32'h5, 32'h1C);
    issue("add", r_ins(3, 4, 5, F_ADD), 32'h0, 1'b1, 32'h0000000C, 1'b0, 32'h7, 32'h20);
    issue("sub", r_ins(3, 4, 6, F_SUB), 32'h0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h7, 32'h24);
    issue("slt", r_ins(6, 3, 7, F_SLT), 32'h0, 1'b1, 32'h1, 1'b0, 32'h5, 32'h28);
    issue("and", r_ins(3, 4, 8, F_AND), 32'h0, 1'b1, 32'h5, 1'b0, 32'h7, 32'h2C);
    issue("or", r_ins(3, 4, 9, F_OR), 32'h0, 1'b1, 32'h7, 1'b0, 32'h7, 32'h30);
    issue("sw5", i_ins(SW, 0, 5, 16'd0), 32'h0, 1'b1, 32'h0, 1'b1, 32'hC, 32'h34);
    issue("sw7", i_ins(SW, 0, 7, 16'd8), 32'h0, 1'b1, 32'h8, 1'b1, 32'h1, 32'h38);
    issue("j40", {J, 26'h10}, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h40);
    issue("addi0", i_ins(ADDI, 0, 0, 16'd9), 32'h0, 1'b1, 32'h9, 1'b0, 32'h0, 32'h44);
    issue("sw0", i_ins(SW, 0, 0, 16'd0), 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 32'h48);
    issue("badop", i_ins(BAD, 3, 3, 16'h0001), 32'h0, 1'b0, 32'h0, 1'b0, 32'h5, 32'h4C);
    issue("sw3", i_ins(SW, 0, 3, 16'd0), 32'h0, 1'b1, 32'h0, 1'b1, 32'h5, 32'h50);
    issue("addineg", i_ins(ADDI, 0, 10, 16'hFFFF), 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h54);
    issue("sw10", i_ins(SW, 3, 10, 16'hFFFB), 32'h0, 1'b1, 32'h0, 1'b1, 32'hFFFFFFFF, 32'h58);

    if (sbq.size() != 0) chk("sb_drain", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
